// File: rtl/soc_io_if.sv
// Memory-mapped IO bus between the CPU-side master and the soc_io peripheral block.
interface soc_io_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] io_rdata;
    logic        io_rvalid;

    modport master (
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  io_rdata, io_rvalid
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output io_rdata, io_rvalid
    );
endinterface

// File: rtl/soc_io.sv
// SoC IO block: LED register, 8N1 UART transmitter and free-running timer,
// decoded from the memory bus when address bit 22 is set.
module soc_io #(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned NUM_LEDS    = 5
) (
    input  logic                clk,
    input  logic                RESET,
    soc_io_if.slave             bus,
    output logic [NUM_LEDS-1:0] LEDS,
    output logic                TXD
);
    localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] REG_LEDS   = 3'd0;
    localparam logic [2:0] REG_UART   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_TIMER  = 3'd3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    uart_state_t      state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [31:0]      timer;

    logic        io_sel_c;
    logic [2:0]  reg_idx_c;
    logic        wr_c;
    logic        rd_c;
    logic        busy_c;
    logic        div_last_c;
    logic [31:0] rd_mux_c;
    logic        unused_c;

    // Address decode; only bit 22 and the word index take part
    assign io_sel_c   = bus.mem_addr[22];
    assign reg_idx_c  = bus.mem_addr[4:2];
    assign wr_c       = io_sel_c && (|bus.mem_wmask);
    assign rd_c       = io_sel_c && bus.mem_rstrb;
    assign busy_c     = (state != IDLE);
    assign div_last_c = (div_cnt == DIV_W'(DIV - 1));
    assign unused_c   = ^{bus.mem_addr, bus.mem_wdata};

    // Read mux sees pre-write register values
    always_comb begin
        rd_mux_c = 32'h0;
        case (reg_idx_c)
            REG_LEDS:   rd_mux_c = 32'(LEDS);
            REG_STATUS: rd_mux_c = {31'h0, busy_c};
            REG_TIMER:  rd_mux_c = timer;
            default:    rd_mux_c = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            LEDS          <= '0;
            timer         <= 32'h0;
            bus.io_rdata  <= 32'h0;
            bus.io_rvalid <= 1'b0;
        end else begin
            bus.io_rvalid <= rd_c;
            if (rd_c) begin
                bus.io_rdata <= rd_mux_c;
            end
            if (wr_c && (reg_idx_c == REG_LEDS)) begin
                LEDS <= bus.mem_wdata[NUM_LEDS-1:0];
            end
            if (wr_c && (reg_idx_c == REG_TIMER)) begin
                timer <= 32'h0;
            end else begin
                timer <= timer + 32'd1;
            end
        end
    end

    // UART transmitter; TXD is registered so each bit starts on the state change
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h0;
            TXD     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_c && (reg_idx_c == REG_UART)) begin
                        shift   <= bus.mem_wdata[7:0];
                        TXD     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= 3'd0;
                        state   <= START;
                    end
                end
                START: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        TXD     <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            TXD   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            TXD     <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
